csr_timer_bank: RTL

Multi-channel CSR-mapped timer: the parametrised successor of the single-compare CSR timer. It has one shared prescaled counter, CHANNELS compare channels each in one-shot or periodic-reload mode, per-channel pending and mask bits, and per-channel interrupt outputs. It sits on the core's CSR side-bus next to the other CSR peripherals, and its rdata/valid are ORed into the shared return path.

---
 rtl/csr_timer_bank.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/csr_timer_bank.sv
// csr_timer_bank: multi-channel timer on the CSR side-bus.
// One shared prescaled up-counter feeds CHANNELS compare channels. Each channel
// runs one-shot or periodic and has pending and mask bits. Per-channel irq is
// pending & mask.
// Optional feature macro: CSR_TIMER_BANK_CAPTURE_EN. When it is defined, the
// block adds a `capture` input, a CAPTURE register at offset 4+2*CHANNELS and
// a capture flag in CTRL[24].
//
// Bus handshake: in cycle N, `read` qualifies `addr` and both are registered.
// In cycle N+1, `valid` claims the access when the registered address is in the
// window, and `rdata` shows the current register value (0 when valid=0).
// `modify`/`wdata` in cycle N+1 act on the registered address at the edge that
// ends N+1, so a read-modify-write never needs a second address phase.
module csr_timer_bank #(
  parameter logic [11:0] BASE_ADDR      = 12'hBC4,
  parameter int          CHANNELS       = 4,
  parameter int          WIDTH          = 32,
  parameter int          PRESCALE_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                read,
  input  logic [2:0]          modify,
  input  logic [31:0]         wdata,
  input  logic [11:0]         addr,
`ifdef CSR_TIMER_BANK_CAPTURE_EN
  input  logic                capture,
`endif
  output logic [31:0]         rdata,
  output logic                valid,
  output logic [CHANNELS-1:0] irq,
  output logic                irq_any,
  input  logic                AVOID_WARNING
);

  // Offset of the first register after the compare/period pairs.
  localparam int NREGS = 4 + 2 * CHANNELS;
`ifdef CSR_TIMER_BANK_CAPTURE_EN
  localparam int WINDOW = NREGS + 1;
`else
  localparam int WINDOW = NREGS;
`endif

  // Access latch
  logic        read_q;
  logic [11:0] addr_q;

  // Timer state
  logic [WIDTH-1:0]          count_q, count_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [PRESCALE_WIDTH-1:0] div_q, div_d;
  logic [CHANNELS-1:0]       en_q, en_d;
  logic [CHANNELS-1:0]       per_q, per_d;
  logic [CHANNELS-1:0]       mask_q, mask_d;
  logic [CHANNELS-1:0]       pend_q, pend_d;
  logic [WIDTH-1:0]          cmp_q [CHANNELS];
  logic [WIDTH-1:0]          cmp_d [CHANNELS];
  logic [WIDTH-1:0]          prd_q [CHANNELS];
  logic [WIDTH-1:0]          prd_d [CHANNELS];

  // Decode and write path
  logic [11:0]         off;
  logic                in_win;
  logic [31:0]         reg_val;
  logic [31:0]         new_val;
  logic                wr_any;
  logic                wr_count;
  logic                wr_presc;
  logic                wr_ctrl;
  logic                wr_pend;
  logic [CHANNELS-1:0] wr_cmp;
  logic [CHANNELS-1:0] wr_prd;

  // Timer events
  logic                tick;
  logic [WIDTH-1:0]    count_inc;
  logic [CHANNELS-1:0] match;

`ifdef CSR_TIMER_BANK_CAPTURE_EN
  logic             cap_s1_q;
  logic             cap_s2_q;
  logic             cap_s3_q;
  logic             cap_rise;
  logic             capf_q, capf_d;
  logic [WIDTH-1:0] capture_q, capture_d;
`endif

  assign off    = addr_q - BASE_ADDR;
  assign in_win = (off < 12'(WINDOW));
  assign valid  = read_q & in_win;
  assign rdata  = valid ? reg_val : 32'd0;

  assign irq     = pend_q & mask_q;
  assign irq_any = |irq;

  // Register the address phase of every access; modify follows one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      read_q <= 1'b0;
      addr_q <= 12'd0;
    end else begin
      read_q <= read;
      addr_q <= addr;
    end
  end

  // Read mux: value of the register selected by the latched address.
  always_comb begin
    reg_val = 32'd0;
    case (off)
      12'd0: reg_val[WIDTH-1:0] = count_q;
      12'd1: reg_val[PRESCALE_WIDTH-1:0] = presc_q;
      12'd2: begin
        reg_val[CHANNELS-1:0]    = en_q;
        reg_val[8 +: CHANNELS]   = per_q;
        reg_val[16 +: CHANNELS]  = mask_q;
`ifdef CSR_TIMER_BANK_CAPTURE_EN
        reg_val[24]              = capf_q;
`endif
      end
      12'd3: reg_val[CHANNELS-1:0] = pend_q;
      default: begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (off == 12'(4 + 2 * k)) reg_val[WIDTH-1:0] = cmp_q[k];
          if (off == 12'(5 + 2 * k)) reg_val[WIDTH-1:0] = prd_q[k];
        end
`ifdef CSR_TIMER_BANK_CAPTURE_EN
        if (off == 12'(NREGS)) reg_val[WIDTH-1:0] = capture_q;
`endif
      end
    endcase
  end

  // Modify arithmetic on the selected register, then per-register write strobes.
  always_comb begin
    new_val = reg_val;
    case (modify)
      3'd1:    new_val = wdata;
      3'd2:    new_val = reg_val | wdata;
      3'd3:    new_val = reg_val & ~wdata;
      default: new_val = reg_val;
    endcase
    wr_any   = in_win & ((modify == 3'd1) | (modify == 3'd2) | (modify == 3'd3));
    wr_count = wr_any & (off == 12'd0);
    wr_presc = wr_any & (off == 12'd1);
    wr_ctrl  = wr_any & (off == 12'd2);
    wr_pend  = wr_any & (off == 12'd3);
    wr_cmp   = '0;
    wr_prd   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      wr_cmp[k] = wr_any & (off == 12'(4 + 2 * k));
      wr_prd[k] = wr_any & (off == 12'(5 + 2 * k));
    end
  end

  // Prescaler and counter: tick when the divider reaches zero; a COUNT write
  // beats the tick, and a PRESCALE write restarts the divide period.
  always_comb begin
    tick      = (div_q == '0);
    count_inc = count_q + WIDTH'(1);
    presc_d   = wr_presc ? new_val[PRESCALE_WIDTH-1:0] : presc_q;
    if (wr_presc)  div_d = new_val[PRESCALE_WIDTH-1:0];
    else if (tick) div_d = presc_q;
    else           div_d = div_q - PRESCALE_WIDTH'(1);
    if (wr_count)  count_d = new_val[WIDTH-1:0];
    else if (tick) count_d = count_inc;
    else           count_d = count_q;
  end

  // Channel match fires in the cycle COUNT steps onto COMPARE; no match when
  // software overwrites COUNT in the same cycle.
  always_comb begin
    match = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      match[k] = tick & ~wr_count & en_q[k] & (count_inc == cmp_q[k]);
    end
  end

  // Channel next state: software compare writes beat the periodic reload,
  // hardware pending set beats a software clear, one-shot match disarms.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      cmp_d[k] = cmp_q[k];
      prd_d[k] = prd_q[k];
      if (wr_cmp[k])                cmp_d[k] = new_val[WIDTH-1:0];
      else if (match[k] & per_q[k]) cmp_d[k] = cmp_q[k] + prd_q[k];
      if (wr_prd[k])                prd_d[k] = new_val[WIDTH-1:0];
    end
    if (wr_ctrl) begin
      en_d   = new_val[CHANNELS-1:0];
      per_d  = new_val[8 +: CHANNELS];
      mask_d = new_val[16 +: CHANNELS];
    end else begin
      en_d   = en_q & ~(match & ~per_q);
      per_d  = per_q;
      mask_d = mask_q;
    end
    pend_d = (wr_pend ? new_val[CHANNELS-1:0] : pend_q) | match;
  end

  // Counter, prescaler and control flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      presc_q <= '0;
      div_q   <= '0;
      en_q    <= '0;
      per_q   <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      en_q    <= en_d;
      per_q   <= per_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
    end
  end

  // Per-channel compare and period flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < CHANNELS; k++) begin
        cmp_q[k] <= '0;
        prd_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        cmp_q[k] <= cmp_d[k];
        prd_q[k] <= prd_d[k];
      end
    end
  end

`ifdef CSR_TIMER_BANK_CAPTURE_EN
  // Capture next state: rising edge of the synchronised pin snapshots COUNT;
  // the hardware flag set beats a software clear of CTRL[24].
  always_comb begin
    cap_rise  = cap_s2_q & ~cap_s3_q;
    capture_d = cap_rise ? count_q : capture_q;
    capf_d    = (wr_ctrl ? new_val[24] : capf_q) | cap_rise;
  end

  // Two-flop synchroniser, edge flop, and capture register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_s1_q  <= 1'b0;
      cap_s2_q  <= 1'b0;
      cap_s3_q  <= 1'b0;
      capf_q    <= 1'b0;
      capture_q <= '0;
    end else begin
      cap_s1_q  <= capture;
      cap_s2_q  <= cap_s1_q;
      cap_s3_q  <= cap_s2_q;
      capf_q    <= capf_d;
      capture_q <= capture_d;
    end
  end
`endif

  // Bits of the write path that are narrower registers do not consume.
  logic unused_ok;
  assign unused_ok = ^{AVOID_WARNING, wdata, new_val};

endmodule
